// File: rtl/if_pkg.sv
// ----------------------------------------------------------------------------
// if_pkg
// Shared types and constants for the instruction-fetch front end.
//   INSTR_W / ADDR_W   : instruction and address widths
//   DEFAULT_RESET_PC   : default program counter after reset
//   NOP_INSTR          : value that prefetch storage is cleared to
//   fetch_entry_t      : one prefetched instruction plus its PC+4
// ----------------------------------------------------------------------------
package if_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc4;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// ----------------------------------------------------------------------------
// if_fifo
// Small synchronous FIFO of fetch_entry_t used as the prefetch buffer.
// Ports:
//   clk_i, rst_ni   : clock, synchronous active-low reset (clears storage)
//   push_i, entry_i : write entry_i at the tail
//   pop_i           : drop the head entry
//   flush_i         : empty the FIFO (wins over push/pop)
//   head_o          : current head entry (stale when count_o == 0)
//   count_o         : number of valid entries, 0..DEPTH
// The owner never pushes when full nor pops when empty.
// ----------------------------------------------------------------------------
module if_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fetch_entry_t entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{instr: NOP_INSTR, pc4: '0};
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch front end: owns the PC, issues one request per cycle to a
// synchronous instruction memory (data returns the cycle after imem_req),
// buffers returns in a prefetch FIFO and hands them to decode with PC+4.
//
// Ports:
//   CLK, RST_N              : clock, synchronous active-low reset
//   imem_req, imem_addr     : fetch request and word-aligned address (the PC)
//   imem_rdata              : instruction, valid one cycle after imem_req
//   redirect, redirect_pc   : taken branch from EX/MEM and its target
//   id_ready                : decode accepts the head (low = stall)
//   id_valid, id_instr,
//   id_pc4                  : head instruction and its PC+4 towards IF/ID
//   perf_fetch, perf_stall  : delivered instructions / stalled cycles
//
// Handshake: an entry transfers on every cycle where id_valid && id_ready;
// id_valid and the head payload stay stable until that transfer or a
// redirect/reset.
//
// Optional feature: define IF_PERF_CNT_EN to build the two 32-bit performance
// counters; without it perf_fetch and perf_stall are tied to 0.
// ----------------------------------------------------------------------------
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc4,
  output logic [31:0]        perf_fetch,
  output logic [31:0]        perf_stall
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc4_q, inflight_pc4_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] pc_plus4;

  logic [CW-1:0]     count;
  logic [CW:0]       occ;
  fetch_entry_t      fifo_head, ret_entry, head;
  logic              fifo_empty, head_valid, pop, push, fifo_pop, issue;

  assign pc_plus4   = pc_q + ADDR_W'(4);
  assign fifo_empty = (count == '0);
  assign ret_entry  = '{instr: imem_rdata, pc4: inflight_pc4_q};

  // With the FIFO empty, the returning instruction is shown to decode
  // directly, which gives the one-cycle fetch-to-IF/ID latency. A return in
  // a redirect cycle is wrong-path and is never exposed.
  assign head_valid = RST_N && (!fifo_empty || (inflight_q && !redirect));
  assign head       = (fifo_empty && inflight_q) ? ret_entry : fifo_head;
  assign pop        = head_valid && id_ready;
  assign fifo_pop   = pop && !fifo_empty;
  assign push       = inflight_q && !redirect && !(pop && fifo_empty);

  // Credit check: entries held plus the one in flight, less the one leaving
  // this cycle. Counting the pop lets requests resume in the same cycle a
  // stall releases, while still never overflowing the FIFO.
  assign occ   = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue = RST_N && !redirect && (occ < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    pc_d           = pc_q;
    inflight_pc4_d = inflight_pc4_q;
    inflight_d     = issue;
    if (redirect) begin
      pc_d = redirect_pc & ~ADDR_W'(3);
    end else if (issue) begin
      pc_d           = pc_plus4;
      inflight_pc4_d = pc_plus4;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc_q           <= RESET_PC;
      inflight_q     <= 1'b0;
      inflight_pc4_q <= '0;
    end else begin
      pc_q           <= pc_d;
      inflight_q     <= inflight_d;
      inflight_pc4_q <= inflight_pc4_d;
    end
  end

  if_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (push),
    .entry_i (ret_entry),
    .pop_i   (fifo_pop),
    .flush_i (redirect),
    .head_o  (fifo_head),
    .count_o (count)
  );

  // Outputs read zero while reset is held, even before the clearing edge.
  assign imem_req  = issue;
  assign imem_addr = RST_N ? pc_q : '0;
  assign id_valid  = head_valid;
  assign id_instr  = RST_N ? head.instr : '0;
  assign id_pc4    = RST_N ? head.pc4 : '0;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // A pop in a redirect cycle is still a delivered instruction.
  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (pop)                     perf_fetch_d = perf_fetch_q + 32'd1;
    if (head_valid && !id_ready) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch = RST_N ? perf_fetch_q : '0;
  assign perf_stall = RST_N ? perf_stall_q : '0;
`else
  assign perf_fetch = '0;
  assign perf_stall = '0;
`endif

endmodule
